// File: rtl/qpsk_pkg.sv
// Shared QPSK transmit constants: default polyphase geometry, the reset RRC
// coefficient image and the MAC accumulator sizing rule.
package qpsk_pkg;

  localparam int OS_DEFAULT    = 4;
  localparam int NBAUD_DEFAULT = 6;
  localparam int CW_DEFAULT    = 8;

  // Tap 0 sits in the most significant byte; the response is symmetric about 11.5.
  localparam logic [OS_DEFAULT*NBAUD_DEFAULT*CW_DEFAULT-1:0] RRC_COEF_INIT =
    192'hFFFDFCFE_03090B05_F8F42064_6420F4F8_050B0903_FEFCFDFF;

  function automatic int acc_width(input int cw, input int nbaud);
    return cw + $clog2(nbaud) + 1;
  endfunction

endpackage

// File: rtl/tx_polyphase_fir_if.sv
// Symbol, coefficient-write and sample-output signals of the polyphase TX filter.
interface tx_polyphase_fir_if
  import qpsk_pkg::*;
#(
  parameter int AW = 5,
  parameter int CW = CW_DEFAULT,
  parameter int OW = 8
);
  logic                 i_enable;
  logic                 i_sym_i;
  logic                 i_sym_q;
  logic                 i_coef_wr;
  logic [AW-1:0]        i_coef_addr;
  logic signed [CW-1:0] i_coef_data;
  logic                 o_valid;
  logic signed [OW-1:0] o_i;
  logic signed [OW-1:0] o_q;
  logic                 o_sym_req;

  modport master (
    output i_enable, i_sym_i, i_sym_q, i_coef_wr, i_coef_addr, i_coef_data,
    input  o_valid, o_i, o_q, o_sym_req
  );

  modport slave (
    input  i_enable, i_sym_i, i_sym_q, i_coef_wr, i_coef_addr, i_coef_data,
    output o_valid, o_i, o_q, o_sym_req
  );
endinterface

// File: rtl/tx_fir_branch.sv
// One channel of the polyphase filter: symbol history with fill bits, a
// +/-h multiply-free MAC over the current phase's taps, then shift and saturate.
module tx_fir_branch
  import qpsk_pkg::*;
#(
  parameter int NBAUD = NBAUD_DEFAULT,
  parameter int CW    = CW_DEFAULT,
  parameter int OW    = 8,
  parameter int SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic                 sym,
  input  logic signed [CW-1:0] h [NBAUD],
  output logic signed [OW-1:0] y
);

  localparam int ACC_W = acc_width(CW, NBAUD);
  localparam int EXT_W = ACC_W + OW;
  localparam int KW    = (NBAUD > 1) ? $clog2(NBAUD) : 1;

  logic [NBAUD-1:0]        sym_r, fill_r;
  logic [NBAUD-1:0]        sym_v, fill_v;
  logic signed [ACC_W-1:0] acc;

  function automatic logic signed [ACC_W-1:0] scale(input logic signed [ACC_W-1:0] v);
    return v >>> SHIFT;
  endfunction

  function automatic logic signed [OW-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [EXT_W-1:0] ext, hi, lo;
    ext         = EXT_W'(v);
    hi          = '0;
    hi[OW-2:0]  = '1;
    lo          = '1;
    lo[OW-2:0]  = '0;
    if (ext > hi)      return hi[OW-1:0];
    else if (ext < lo) return lo[OW-1:0];
    else               return ext[OW-1:0];
  endfunction

  // The MAC sees the history as it will be after this cycle's shift.
  assign sym_v  = shift_en ? ((sym_r << 1) | NBAUD'(sym))   : sym_r;
  assign fill_v = shift_en ? ((fill_r << 1) | NBAUD'(1'b1)) : fill_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      sym_r  <= '0;
      fill_r <= '0;
    end else begin
      sym_r  <= sym_v;
      fill_r <= fill_v;
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < NBAUD; k++) begin
      if (fill_v[KW'(k)]) begin
        acc = sym_v[KW'(k)] ? acc + ACC_W'(h[KW'(k)]) : acc - ACC_W'(h[KW'(k)]);
      end
    end
  end

  assign y = saturate(scale(acc));

endmodule

// File: rtl/tx_polyphase_fir.sv
// QPSK transmit pulse-shaping filter: OS polyphase branches per symbol, shared
// runtime-writable coefficient file, I and Q branches, one-cycle output latency.
module tx_polyphase_fir
  import qpsk_pkg::*;
#(
  parameter int OS    = OS_DEFAULT,
  parameter int NBAUD = NBAUD_DEFAULT,
  parameter int CW    = CW_DEFAULT,
  parameter int OW    = 8,
  parameter int SHIFT = 0,
  parameter logic [OS*NBAUD*CW-1:0] COEF_INIT = RRC_COEF_INIT
) (
  input logic               clk,
  input logic               reset,
  tx_polyphase_fir_if.slave bus
);

  localparam int NTAPS = OS * NBAUD;
  localparam int AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int PW    = (OS > 1) ? $clog2(OS) : 1;
  localparam int KW    = (NBAUD > 1) ? $clog2(NBAUD) : 1;

  logic [PW-1:0]        phase;
  logic                 sym_req;
  logic signed [CW-1:0] coef    [NTAPS];
  logic signed [CW-1:0] h_phase [NBAUD];
  logic signed [OW-1:0] y_i, y_q;
  logic                 vld_p1;
  logic signed [OW-1:0] i_p1, q_p1;

  assign sym_req       = bus.i_enable && (phase == '0);
  assign bus.o_sym_req = sym_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
    end else if (bus.i_enable) begin
      phase <= (phase == PW'(OS - 1)) ? '0 : phase + 1'b1;
    end
  end

  // Writes land at the clock edge, so a same-cycle computation still reads the old tap.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NTAPS; n++) begin
        coef[AW'(n)] <= COEF_INIT[(NTAPS-n)*CW-1 -: CW];
      end
    end else if (bus.i_coef_wr && (int'(bus.i_coef_addr) < NTAPS)) begin
      coef[bus.i_coef_addr] <= bus.i_coef_data;
    end
  end

  always_comb begin
    for (int k = 0; k < NBAUD; k++) begin
      h_phase[KW'(k)] = coef[AW'(k * OS) + AW'(phase)];
    end
  end

  tx_fir_branch #(
    .NBAUD (NBAUD),
    .CW    (CW),
    .OW    (OW),
    .SHIFT (SHIFT)
  ) u_branch_i (
    .clk      (clk),
    .reset    (reset),
    .shift_en (sym_req),
    .sym      (bus.i_sym_i),
    .h        (h_phase),
    .y        (y_i)
  );

  tx_fir_branch #(
    .NBAUD (NBAUD),
    .CW    (CW),
    .OW    (OW),
    .SHIFT (SHIFT)
  ) u_branch_q (
    .clk      (clk),
    .reset    (reset),
    .shift_en (sym_req),
    .sym      (bus.i_sym_q),
    .h        (h_phase),
    .y        (y_q)
  );

  // Stage p1: registered outputs, held between enable strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      i_p1   <= '0;
      q_p1   <= '0;
    end else begin
      vld_p1 <= bus.i_enable;
      if (bus.i_enable) begin
        i_p1 <= y_i;
        q_p1 <= y_q;
      end
    end
  end

  assign bus.o_valid = vld_p1;
  assign bus.o_i     = i_p1;
  assign bus.o_q     = q_p1;

endmodule

// File: tb/tb_tx_polyphase_fir.sv
// Scoreboard bench for tx_polyphase_fir: two instances (SHIFT 0 and 3) share
// stimulus; a symbol-history model predicts every output sample.
module tb_tx_polyphase_fir;
  import qpsk_pkg::*;

  localparam int OS = 4, NBAUD = 6, NTAPS = 24, CW = 8, OW = 8, AW = 5, SH1 = 3;

  typedef struct {
    int i0;
    int q0;
    int i1;
    int q1;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  tx_polyphase_fir_if #(.AW(AW), .CW(CW), .OW(OW)) if0 ();
  tx_polyphase_fir_if #(.AW(AW), .CW(CW), .OW(OW)) if1 ();

  assign if1.i_enable    = if0.i_enable;
  assign if1.i_sym_i     = if0.i_sym_i;
  assign if1.i_sym_q     = if0.i_sym_q;
  assign if1.i_coef_wr   = if0.i_coef_wr;
  assign if1.i_coef_addr = if0.i_coef_addr;
  assign if1.i_coef_data = if0.i_coef_data;

  tx_polyphase_fir #(.OS(OS), .NBAUD(NBAUD), .CW(CW), .OW(OW), .SHIFT(0)) dut0 (
    .clk (clk), .reset (reset), .bus (if0.slave)
  );
  tx_polyphase_fir #(.OS(OS), .NBAUD(NBAUD), .CW(CW), .OW(OW), .SHIFT(SH1)) dut1 (
    .clk (clk), .reset (reset), .bus (if1.slave)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  bit   hist_i[$];
  bit   hist_q[$];
  int   coef_init[NTAPS];
  int   coef_m[NTAPS];
  int   phase_m  = 0;
  bit   started  = 0;
  bit   req_chk  = 0;
  bit   exp_req  = 0;
  bit   en_seen  = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Filter output = sum over stored symbols (newest first) of +/-h at the current phase.
  function automatic int conv(input bit hist[$]);
    int acc = 0;
    for (int k = 0; k < hist.size(); k++)
      acc += (hist[k] ? 1 : -1) * coef_m[k*OS + phase_m];
    return acc;
  endfunction

  task automatic cycle(input bit rst, input bit en, input bit si, input bit sq,
                       input bit wr, input int addr, input int data);
    int ai, aq;
    @(posedge clk);
    #1;
    reset           = rst;
    if0.i_enable    = en;
    if0.i_sym_i     = si;
    if0.i_sym_q     = sq;
    if0.i_coef_wr   = wr;
    if0.i_coef_addr = AW'(addr);
    if0.i_coef_data = CW'(data);
    started = 1;
    req_chk = !rst;
    exp_req = en && (phase_m == 0);
    if (rst) begin
      hist_i.delete();
      hist_q.delete();
      phase_m = 0;
      coef_m  = coef_init;
    end else begin
      if (en) begin
        if (phase_m == 0) begin
          hist_i.push_front(si);
          hist_q.push_front(sq);
          if (hist_i.size() > NBAUD) begin
            void'(hist_i.pop_back());
            void'(hist_q.pop_back());
          end
        end
        ai = conv(hist_i);
        aq = conv(hist_q);
        sb.push_back('{sat(ai), sat(aq), sat(ai >>> SH1), sat(aq >>> SH1)});
        phase_m = (phase_m + 1) % OS;
      end
      if (wr && addr < NTAPS) coef_m[addr] = data;
    end
  endtask

  task automatic en_sym(input bit si, input bit sq);
    cycle(0, 1, si, sq, 0, 0, 0);
  endtask

  always @(posedge clk) en_seen <= (reset === 1'b0) && (if0.i_enable === 1'b1);

  // Monitor: valid timing, symbol-request strobe, and scoreboard pops.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      chk("o_valid", if0.o_valid, int'(en_seen));
      chk("o_valid_s3", if1.o_valid, int'(en_seen));
      if (req_chk) chk("o_sym_req", if0.o_sym_req, int'(exp_req));
      if (if0.o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard_empty: got valid output, expected none at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("o_i", if0.o_i, e.i0);
          chk("o_q", if0.o_q, e.q0);
          chk("o_i_s3", if1.o_i, e.i1);
          chk("o_q_s3", if1.o_q, e.q1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NTAPS*CW-1:0] img;
    int gaps[10] = '{1, 0, 1, 0, 0, 1, 1, 0, 1, 1};
    img = RRC_COEF_INIT;
    for (int n = 0; n < NTAPS; n++) coef_init[n] = int'($signed(img[(NTAPS-n)*CW-1 -: CW]));
    coef_m = coef_init;
    reset = 1'b1;
    if0.i_enable = 0; if0.i_sym_i = 0; if0.i_sym_q = 0;
    if0.i_coef_wr = 0; if0.i_coef_addr = '0; if0.i_coef_data = '0;

    // Reset dominates a simultaneous enable and coefficient write.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 1, 3, 77);
    cycle(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("rst_o_i", if0.o_i, 0);
    chk("rst_o_q", if0.o_q, 0);
    chk("rst_o_i_s3", if1.o_i, 0);
    chk("rst_o_q_s3", if1.o_q, 0);

    // Impulse: h[n]=n+1, I=1 then I=0.
    for (int n = 0; n < NTAPS; n++) cycle(0, 0, 0, 0, 1, n, n + 1);
    repeat (4) en_sym(1, 0);
    repeat (4) en_sym(0, 0);

    // Write h[0]=50 on a phase-0 cycle, then reuse phase 0.
    cycle(0, 1, 1, 1, 1, 0, 50);
    repeat (3) en_sym(0, 0);
    repeat (4) en_sym(0, 1);

    // Enable gaps.
    foreach (gaps[g]) cycle(0, gaps[g] != 0, 1'($urandom), 1'($urandom), 0, 0, 0);

    // Reset at phase 2.
    while (phase_m != 0) en_sym(0, 0);
    en_sym(1, 1);
    en_sym(0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    en_sym(0, 1);
    repeat (3) en_sym(1, 1);

    // Saturation with all taps at 127.
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < NTAPS; n++) cycle(0, 0, 0, 0, 1, n, 127);
    repeat (28) en_sym(1, 0);

    // Randomized traffic, including out-of-range writes and occasional resets.
    repeat (400) begin
      cycle(($urandom % 80) == 0, ($urandom % 4) != 0, 1'($urandom), 1'($urandom),
            ($urandom % 6) == 0, $urandom_range(0, 31), $urandom_range(0, 255) - 128);
    end

    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
